icetap_jtag_master: RTL
=======================

# icetap_jtag_master

Host-side JTAG initiator that drives the TAP pins read by the icetap JTAG register block (`tck`/`tdi`/`icetap_tdo` and the TAP-state decode). It accepts IR-shift, DR-shift, TAP-reset and idle-clock commands over a valid/ready interface. It generates TCK/TMS/TDI, samples TDO, and returns captured shift data. Its intended uses are FPGA-internal self-test of the icetap scan path, and a bridge from a UART/SPI host.

## Interface
- `MAX_SHIFT_BITS`, default 64: widest IR/DR shift per command.
- `TCK_DIV`, default 2: `scan_clk` cycles per TCK half-period; must be ≥1.
- `LEN_BITS`, localparam: `$clog2(MAX_SHIFT_BITS+1)`.

Ports:
- `scan_clk` in 1: sole clock.
- `scan_reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_op` in 2: 0 = TAP reset, 1 = IR shift, 2 = DR shift, 3 = idle clocks.
- `cmd_len` in `LEN_BITS`: bit count for shifts, TCK count for idle; ignored for TAP reset.
- `cmd_data` in `MAX_SHIFT_BITS`: TDI data, LSB shifted first.
- `rsp_valid` out 1: one-cycle pulse at command completion.
- `rsp_data` out `MAX_SHIFT_BITS`: captured TDO; bit i is the i-th shifted bit; bits ≥ len are 0.
- `jtag_tck` out 1, `jtag_tms` out 1, `jtag_tdi` out 1: TAP drive; all registered.
- `jtag_tdo` in 1: TAP return.

## Operation
- The master tracks the TAP as Run-Test/Idle (RTI) whenever `cmd_ready`=1.
- Command latching:
  - `cmd_op`, `cmd_len` and `cmd_data` are registered on accept.
  - A `cmd_len` above `MAX_SHIFT_BITS` is clamped to `MAX_SHIFT_BITS`.
- States: `AUTO_RST`, `IDLE`, `RUN`, `DONE`.
- TMS sequence per TCK period, starting from RTI:
  - TAP reset: 1,1,1,1,1,0 (6 periods).
  - IR shift: 1,1,0,0, then len bits (TMS=0 except the last bit, TMS=1), then 1,0 (len+6 periods).
  - DR shift: 1,0,0, then len bits as for IR, then 1,0 (len+5 periods).
  - Idle: len periods of TMS=0.
- TDI carries `cmd_data[i]` during shift bit i and is 0 in all other periods.
- TDO sampled during shift bit i is written to `rsp_data[i]`.
- Zero-length commands:
  - IR/DR shift with len=0 generates no TCK; `rsp_valid` pulses with `rsp_data`=0.
  - Idle with len=0 behaves the same way.
- `rsp_data` is 0 for TAP-reset and idle commands.
- `rsp_data` holds its value until the next `rsp_valid`.
- After `scan_reset` deasserts, the master runs the TAP-reset sequence automatically (`AUTO_RST`), without a `rsp_valid` pulse. It then enters `IDLE` with `cmd_ready`=1.

## Timing
- Reset values: `jtag_tck`=0, `jtag_tms`=1, `jtag_tdi`=0, `cmd_ready`=0, `rsp_valid`=0, `rsp_data`=0, state=`AUTO_RST`, phase counter=0.
- TCK period P = 2·`TCK_DIV` cycles.
  - Phase 0: `jtag_tck` goes 0; TMS/TDI update in the same cycle.
  - Phase `TCK_DIV`: `jtag_tck` goes 1, and `jtag_tdo` is registered on that same clock edge.
- Command accepted at cycle t:
  - `cmd_ready` is 0 from t+1.
  - The first period's phase 0 is at t+1.
  - With N = period count, `rsp_valid`=1 and `cmd_ready`=1 at cycle t+1+N·P.
  - Back-to-back: the next command can be accepted in that same cycle.
- Zero-length commands: `rsp_valid` at t+1.
- `jtag_tck` returns to 0 at the start of `DONE` and stays low while idle; `jtag_tms`=0 while idle.
- A `scan_reset` asserted mid-command forces the reset values on the next edge. The in-flight command is dropped without `rsp_valid`, and `AUTO_RST` reruns.
- `cmd_valid` while `cmd_ready`=0 is ignored and not queued.
- `rsp_valid` is never asserted for two consecutive cycles.

## Test plan
- Release reset → TMS 1,1,1,1,1,0 over 6 TCK periods (24 cycles at `TCK_DIV`=2); `cmd_ready` rises in the cycle after; no `rsp_valid`.
- IR shift, len=4, data=0xA, `jtag_tdo` looped from `jtag_tdi` → TMS 1,1,0,0,0,0,0,1,1,0; TDI bits 0,1,0,1; `rsp_data`=0xA.
- DR shift, len=8, data=0x5A, `jtag_tdo` tied 1, `TCK_DIV`=2, accepted at t → 13 periods; `rsp_valid` at t+53; `rsp_data`=0xFF.
- DR shift with len=0, then idle with len=3 held back-to-back on `cmd_valid` → first `rsp_valid` at t+1 with no TCK; second command accepted in the same cycle; 3 TCK periods with TMS=0.
- Assert `scan_reset` during bit 5 of a 32-bit DR shift → next cycle `jtag_tms`=1, `jtag_tck`=0, no `rsp_valid`; the auto-reset sequence repeats.
- `cmd_len`=127 with `MAX_SHIFT_BITS`=64 → exactly 64 shift bits.

Source files
------------

// File: rtl/icetap_jtag_master_if.sv
// rtl/icetap_jtag_master_if.sv - command/response bundle between a host and the icetap JTAG master
interface icetap_jtag_master_if #(
    parameter int MAX_SHIFT_BITS = 64
);
    localparam int LEN_BITS = $clog2(MAX_SHIFT_BITS + 1);

    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [1:0]                cmd_op;
    logic [LEN_BITS-1:0]       cmd_len;
    logic [MAX_SHIFT_BITS-1:0] cmd_data;
    logic                      rsp_valid;
    logic [MAX_SHIFT_BITS-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_data,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/icetap_jtag_master.sv
// rtl/icetap_jtag_master.sv - JTAG TAP initiator running IR/DR shifts, TAP resets and idle clocks
module icetap_jtag_master #(
    parameter int MAX_SHIFT_BITS = 64,
    parameter int TCK_DIV        = 2
) (
    input  logic                scan_clk,
    input  logic                scan_reset,
    icetap_jtag_master_if.slave cmd,
    output logic                jtag_tck,
    output logic                jtag_tms,
    output logic                jtag_tdi,
    input  logic                jtag_tdo
);
    localparam int LEN_BITS = $clog2(MAX_SHIFT_BITS + 1);
    localparam int IW       = (MAX_SHIFT_BITS > 1) ? $clog2(MAX_SHIFT_BITS) : 1;
    localparam int P        = 2 * TCK_DIV;
    localparam int PW       = $clog2(P + 1);
    localparam int CW       = $clog2(MAX_SHIFT_BITS + 7);

    localparam logic [1:0] OP_RST  = 2'd0;
    localparam logic [1:0] OP_IR   = 2'd1;
    localparam logic [1:0] OP_DR   = 2'd2;
    localparam logic [1:0] OP_IDLE = 2'd3;

    typedef enum logic [1:0] {AUTO_RST, IDLE, RUN, DONE} state_t;

    state_t                    state_q, state_d;
    logic [PW-1:0]             phase_q, phase_d;
    logic [CW-1:0]             pidx_q, pidx_d;
    logic [CW-1:0]             nper_q, nper_d;
    logic [1:0]                op_q, op_d;
    logic [LEN_BITS-1:0]       len_q, len_d;
    logic [MAX_SHIFT_BITS-1:0] data_q, data_d;
    logic [MAX_SHIFT_BITS-1:0] cap_q, cap_d;
    logic [MAX_SHIFT_BITS-1:0] rsp_q, rsp_d;
    logic                      tck_q, tck_d;
    logic                      tms_q, tms_d;
    logic                      tdi_q, tdi_d;
    logic                      ready_q, ready_d;
    logic                      rspv_q, rspv_d;
    logic [LEN_BITS-1:0]       len_clamped;
    logic [CW-1:0]             new_nper;

    function automatic logic [CW-1:0] head_len(input logic [1:0] o);
        case (o)
            OP_IR:   head_len = CW'(4);
            OP_DR:   head_len = CW'(3);
            default: head_len = '0;
        endcase
    endfunction

    function automatic logic [CW-1:0] period_count(input logic [1:0] o, input logic [LEN_BITS-1:0] l);
        if (o == OP_RST)
            period_count = CW'(6);
        else if (o == OP_IDLE)
            period_count = CW'(l);
        else if (l == '0)
            period_count = '0;
        else
            period_count = head_len(o) + CW'(l) + CW'(2);
    endfunction

    function automatic logic in_shift(input logic [1:0] o, input logic [LEN_BITS-1:0] l,
                                      input logic [CW-1:0] k);
        in_shift = ((o == OP_IR) || (o == OP_DR)) && (k >= head_len(o)) && (k < head_len(o) + CW'(l));
    endfunction

    function automatic logic [IW-1:0] bit_index(input logic [1:0] o, input logic [CW-1:0] k);
        bit_index = IW'(k - head_len(o));
    endfunction

    // Shift end is the first period after the data bits: Exit1 -> Update, then back to RTI.
    function automatic logic tms_at(input logic [1:0] o, input logic [LEN_BITS-1:0] l,
                                    input logic [CW-1:0] k);
        logic [CW-1:0] sh_end;
        sh_end = head_len(o) + CW'(l);
        case (o)
            OP_RST:  tms_at = (k < CW'(5));
            OP_IR:   tms_at = (k < CW'(2)) || (k == sh_end - CW'(1)) || (k == sh_end);
            OP_DR:   tms_at = (k == '0) || (k == sh_end - CW'(1)) || (k == sh_end);
            default: tms_at = 1'b0;
        endcase
    endfunction

    function automatic logic tdi_at(input logic [1:0] o, input logic [LEN_BITS-1:0] l,
                                    input logic [MAX_SHIFT_BITS-1:0] d, input logic [CW-1:0] k);
        tdi_at = in_shift(o, l, k) ? d[bit_index(o, k)] : 1'b0;
    endfunction

    assign len_clamped = (cmd.cmd_len > LEN_BITS'(MAX_SHIFT_BITS)) ? LEN_BITS'(MAX_SHIFT_BITS) : cmd.cmd_len;
    assign new_nper    = period_count(cmd.cmd_op, len_clamped);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        pidx_d  = pidx_q;
        nper_d  = nper_q;
        op_d    = op_q;
        len_d   = len_q;
        data_d  = data_q;
        cap_d   = cap_q;
        rsp_d   = rsp_q;
        tck_d   = tck_q;
        tms_d   = tms_q;
        tdi_d   = tdi_q;
        ready_d = ready_q;
        rspv_d  = 1'b0;

        case (state_q)
            AUTO_RST, RUN: begin
                if (state_q == RUN && nper_q == '0) begin
                    state_d = DONE;
                    rspv_d  = 1'b1;
                    ready_d = 1'b1;
                    rsp_d   = '0;
                end else if (phase_q == PW'(P - 1)) begin
                    phase_d = '0;
                    tck_d   = 1'b0;
                    if (pidx_q == nper_q - CW'(1)) begin
                        state_d = (state_q == AUTO_RST) ? IDLE : DONE;
                        rspv_d  = (state_q == RUN);
                        rsp_d   = (state_q == RUN) ? cap_q : rsp_q;
                        ready_d = 1'b1;
                        tms_d   = 1'b0;
                        tdi_d   = 1'b0;
                    end else begin
                        pidx_d = pidx_q + CW'(1);
                        tms_d  = tms_at(op_q, len_q, pidx_q + CW'(1));
                        tdi_d  = tdi_at(op_q, len_q, data_q, pidx_q + CW'(1));
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                    if (phase_q == PW'(TCK_DIV - 1)) begin
                        tck_d = 1'b1;
                        if (in_shift(op_q, len_q, pidx_q))
                            cap_d[bit_index(op_q, pidx_q)] = jtag_tdo;
                    end
                end
            end
            IDLE, DONE: begin
                tck_d = 1'b0;
                tms_d = 1'b0;
                tdi_d = 1'b0;
                if (state_q == DONE)
                    state_d = IDLE;
                if (cmd.cmd_valid && ready_q) begin
                    op_d    = cmd.cmd_op;
                    len_d   = len_clamped;
                    data_d  = cmd.cmd_data;
                    cap_d   = '0;
                    pidx_d  = '0;
                    phase_d = '0;
                    nper_d  = new_nper;
                    if (new_nper == '0) begin
                        // A zero-length command accepted on a response cycle waits one cycle so
                        // responses never land on adjacent cycles.
                        if (state_q == IDLE) begin
                            state_d = DONE;
                            rspv_d  = 1'b1;
                            rsp_d   = '0;
                        end else begin
                            state_d = RUN;
                            ready_d = 1'b0;
                        end
                    end else begin
                        state_d = RUN;
                        ready_d = 1'b0;
                        tms_d   = tms_at(cmd.cmd_op, len_clamped, '0);
                        tdi_d   = tdi_at(cmd.cmd_op, len_clamped, cmd.cmd_data, '0);
                    end
                end
            end
            default: state_d = AUTO_RST;
        endcase
    end

    always_ff @(posedge scan_clk) begin
        if (scan_reset) begin
            state_q <= AUTO_RST;
            phase_q <= '0;
            pidx_q  <= '0;
            nper_q  <= CW'(6);
            op_q    <= OP_RST;
            len_q   <= '0;
            data_q  <= '0;
            cap_q   <= '0;
            rsp_q   <= '0;
            tck_q   <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            ready_q <= 1'b0;
            rspv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            pidx_q  <= pidx_d;
            nper_q  <= nper_d;
            op_q    <= op_d;
            len_q   <= len_d;
            data_q  <= data_d;
            cap_q   <= cap_d;
            rsp_q   <= rsp_d;
            tck_q   <= tck_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            ready_q <= ready_d;
            rspv_q  <= rspv_d;
        end
    end

    assign jtag_tck      = tck_q;
    assign jtag_tms      = tms_q;
    assign jtag_tdi      = tdi_q;
    assign cmd.cmd_ready = ready_q;
    assign cmd.rsp_valid = rspv_q;
    assign cmd.rsp_data  = rsp_q;
endmodule
